// File: rtl/flash_ctrl_pkg.sv
// Shared types and default timing for the parallel NOR flash controller.
package flash_ctrl_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PH_W   = 4;
  localparam int unsigned STS_W  = 8;

  localparam int unsigned DEF_T_SETUP     = 2;
  localparam int unsigned DEF_T_PULSE     = 4;
  localparam int unsigned DEF_T_HOLD      = 2;
  localparam int unsigned DEF_STS_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_STS_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  // Phase counter reload value: a phase of t clocks counts t-1 down to 0.
  function automatic logic [PH_W-1:0] phase_load(input int unsigned t);
    return PH_W'(t - 1);
  endfunction

endpackage

// File: rtl/flash_phase_timer.sv
// Down-counter timing the SETUP, PULSE and HOLD phases.
module flash_phase_timer
  import flash_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  output logic            last_c
);

  logic [PH_W-1:0] cnt;

  // Reload on phase entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - PH_W'(1);
    end
  end

  assign last_c = (cnt == '0);

endmodule

// File: rtl/flash_ctrl.sv
// Single-access byte-wide NOR flash controller with programmable strobe timing.
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned T_SETUP     = DEF_T_SETUP,
  parameter int unsigned T_PULSE     = DEF_T_PULSE,
  parameter int unsigned T_HOLD      = DEF_T_HOLD,
  parameter bit          WAIT_STS    = 1'b0,
  parameter int unsigned STS_TIMEOUT = DEF_STS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] NF_A,
  inout  wire  [DATA_W-1:0] NF_D,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic              NF_WE,
  output logic              NF_BYTE,
  output logic              NF_RP,
  output logic              NF_WP,
  input  logic              NF_STS
);

  localparam logic [PH_W-1:0]  LD_SETUP = phase_load(T_SETUP);
  localparam logic [PH_W-1:0]  LD_PULSE = phase_load(T_PULSE);
  localparam logic [PH_W-1:0]  LD_HOLD  = phase_load(T_HOLD);
  localparam logic [STS_W-1:0] STS_LAST = STS_W'(STS_TIMEOUT - 1);

  state_e            state;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              d_oe;
  logic [STS_W-1:0]  sts_cnt;
  logic              ph_load_c;
  logic [PH_W-1:0]   ph_val_c;
  logic              ph_last_c;

  // Data bus is driven only while a write owns it; reset releases it at once.
  assign NF_D = d_oe ? wdata_q : 'z;

  // Byte mode and write protect are static straps.
  assign NF_BYTE = 1'b0;
  assign NF_WP   = 1'b1;

  // Phase timer reload on entry to SETUP, PULSE and HOLD.
  always_comb begin
    ph_load_c = 1'b0;
    ph_val_c  = LD_SETUP;
    case (state)
      ST_IDLE:  if (req)       begin ph_load_c = 1'b1; ph_val_c = LD_SETUP; end
      ST_SETUP: if (ph_last_c) begin ph_load_c = 1'b1; ph_val_c = LD_PULSE; end
      ST_PULSE: if (ph_last_c) begin ph_load_c = 1'b1; ph_val_c = LD_HOLD;  end
      default:  ;
    endcase
  end

  flash_phase_timer u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load_c),
    .load_val (ph_val_c),
    .last_c   (ph_last_c)
  );

  // Flash powerdown is held until the first clock after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) NF_RP <= 1'b0;
    else     NF_RP <= 1'b1;
  end

  // Transaction sequencer with registered flash strobes and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      d_oe    <= 1'b0;
      sts_cnt <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      NF_A    <= '0;
      NF_CE   <= 1'b1;
      NF_OE   <= 1'b1;
      NF_WE   <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            NF_A    <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            d_oe    <= we;
            NF_CE   <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (ph_last_c) begin
            if (we_q) NF_WE <= 1'b0;
            else      NF_OE <= 1'b0;
            state <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (ph_last_c) begin
            // Capture read data while OE is still low on this edge.
            if (!we_q) rdata <= NF_D;
            NF_WE <= 1'b1;
            NF_OE <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ph_last_c) begin
            d_oe  <= 1'b0;
            NF_CE <= 1'b1;
            if (we_q && WAIT_STS) begin
              sts_cnt <= '0;
              state   <= ST_STS_WAIT;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_STS_WAIT: begin
          if (NF_STS) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (sts_cnt == STS_LAST) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            sts_cnt <= sts_cnt + STS_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
